// File: rtl/imem_loader_pkg.sv
// Shared types for the instruction-memory boot loader: FSM states, default
// address width, word geometry and the frame length type.
package imem_loader_pkg;

  localparam int DEF_ADDR_W = 10;
  localparam int WORD_W     = 32;

  typedef logic [15:0] len_t;

  typedef enum logic [2:0] {
    IDLE,
    LEN_HI,
    LEN_LO,
    DATA,
    CSUM,
    DONE,
    ERR
  } state_t;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Packs a byte stream into big-endian 32-bit words; word/word_valid are
// presented combinationally on the cycle the 4th byte is accepted.
module byte_packer
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr,
  input  logic              en,
  input  logic [7:0]        byte_data,
  output logic [WORD_W-1:0] word,
  output logic              word_valid
);

  logic [WORD_W-9:0] shift_p0;
  logic [1:0]        idx;

  always_ff @(posedge clk) begin
    if (rst || clr) idx <= '0;
    else if (en)    idx <= idx + 2'd1;
  end

  // Only the three most recent bytes are held; the 4th arrives on the bus.
  always_ff @(posedge clk) begin
    if (en) shift_p0 <= {shift_p0[WORD_W-17:0], byte_data};
  end

  assign word       = {shift_p0, byte_data};
  assign word_valid = en && (idx == 2'd3);

endmodule

// File: rtl/imem_loader.sv
// Length-prefixed byte-stream boot loader that fills instruction memory and
// holds the core in reset until a complete image is written.
// Optional trailing checksum byte: define IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DEPTH  = 1 << ADDR_W
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              load_start,
  input  logic              byte_valid,
  input  logic [7:0]        byte_data,
  output logic              byte_ready,
  output logic              imem_we,
  output logic [ADDR_W-1:0] imem_addr,
  output logic [WORD_W-1:0] imem_wdata,
  output logic              cpu_rst,
  output logic              done,
  output logic              error
);

  state_t            state, state_n;
  len_t              n_reg;
  len_t              len_w;
  logic              accept;
  logic              start;
  logic              last_word;
  logic [WORD_W-1:0] word;
  logic              word_valid;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam state_t END_ST = CSUM;
  logic [7:0] csum;
`else
  localparam state_t END_ST = DONE;
`endif

  assign accept    = byte_valid && byte_ready;
  assign start     = load_start && (state == IDLE || state == DONE || state == ERR);
  assign len_w     = {n_reg[15:8], byte_data};
  // The address only advances between words, so it equals the index of the word in flight.
  assign last_word = (len_t'(imem_addr) == n_reg - 16'd1);

  byte_packer u_packer (
    .clk        (clk),
    .rst        (rst),
    .clr        (start),
    .en         (accept && state == DATA),
    .byte_data  (byte_data),
    .word       (word),
    .word_valid (word_valid)
  );

  always_comb begin
    state_n = state;
    case (state)
      IDLE:   if (load_start) state_n = LEN_HI;
      LEN_HI: if (accept) state_n = LEN_LO;
      LEN_LO: begin
        if (accept) begin
          if ({16'd0, len_w} > 32'(DEPTH)) state_n = ERR;
          else if (len_w == 16'd0)         state_n = END_ST;
          else                             state_n = DATA;
        end
      end
      DATA:   if (word_valid && last_word) state_n = END_ST;
`ifdef IMEM_LOADER_CHECKSUM_EN
      CSUM:   if (accept) state_n = (csum + byte_data == 8'd0) ? DONE : ERR;
`endif
      DONE:   if (load_start) state_n = LEN_HI;
      ERR:    if (load_start) state_n = LEN_HI;
      default: state_n = IDLE;
    endcase
  end

  // Stage p0: control registers; status levels lag the state by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      byte_ready <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
      cpu_rst    <= 1'b1;
      imem_we    <= 1'b0;
      imem_addr  <= '0;
      imem_wdata <= '0;
    end else begin
      state      <= state_n;
      byte_ready <= (state_n == LEN_HI) || (state_n == LEN_LO) ||
                    (state_n == DATA)   || (state_n == CSUM);
      done       <= (state == DONE) && (state_n == DONE);
      error      <= (state == ERR)  && (state_n == ERR);
      cpu_rst    <= !((state == DONE) && (state_n == DONE));
      imem_we    <= word_valid;
      if (word_valid) imem_wdata <= word;
      if (state == LEN_LO && state_n == DATA)  imem_addr <= '0;
      else if (imem_we && state == DATA)       imem_addr <= imem_addr + ADDR_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (accept && state == LEN_HI) n_reg[15:8] <= byte_data;
    if (accept && state == LEN_LO) n_reg       <= len_w;
  end

`ifdef IMEM_LOADER_CHECKSUM_EN
  always_ff @(posedge clk) begin
    if (start)                         csum <= '0;
    else if (accept && state == DATA)  csum <= csum + byte_data;
  end
`endif

endmodule

// File: tb/tb_imem_loader.sv
// Directed bench for imem_loader: scoreboard of expected writes checked by a
// write monitor; covers IMEM_LOADER_CHECKSUM_EN frames when that macro is defined.
module tb_imem_loader;

  logic        clk = 1'b0;
  logic        rst, load_start, byte_valid;
  logic [7:0]  byte_data;
  logic        byte_ready, imem_we, cpu_rst, done, error;
  logic [9:0]  imem_addr;
  logic [31:0] imem_wdata;

  int          checks = 0;
  int          failures = 0;
  int          we_count = 0;
  int          snap;
  logic [7:0]  sum8;
  logic [41:0] exp_q[$];

  imem_loader dut (
    .clk        (clk),
    .rst        (rst),
    .load_start (load_start),
    .byte_valid (byte_valid),
    .byte_data  (byte_data),
    .byte_ready (byte_ready),
    .imem_we    (imem_we),
    .imem_addr  (imem_addr),
    .imem_wdata (imem_wdata),
    .cpu_rst    (cpu_rst),
    .done       (done),
    .error      (error)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (imem_we === 1'b1) begin
      logic [41:0] e;
      we_count++;
      if (exp_q.size() == 0) begin
        check("unexpected_write", {22'd0, imem_addr}, 32'hFFFF_FFFF);
      end else begin
        e = exp_q.pop_front();
        check("write_addr", {22'd0, imem_addr}, {22'd0, e[41:32]});
        check("write_data", imem_wdata, e[31:0]);
      end
    end
  end

  task automatic start_load();
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    sum8 = 8'd0;
  endtask

  task automatic send_byte(input logic [7:0] b, input int gap);
    bit acc = 0;
    repeat ($urandom_range(0, gap)) begin
      @(posedge clk); #1;
    end
    byte_valid = 1'b1;
    byte_data  = b;
    for (int i = 0; i < 200 && !acc; i++) begin
      @(negedge clk);
      acc = (byte_ready === 1'b1);
      @(posedge clk); #1;
    end
    byte_valid = 1'b0;
    if (!acc) check("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic send_data(input logic [7:0] b, input int gap);
    sum8 = sum8 + b;
    send_byte(b, gap);
  endtask

  task automatic end_frame();
`ifdef IMEM_LOADER_CHECKSUM_EN
    send_byte(8'd0 - sum8, 0);
`endif
  endtask

  task automatic settle2();
    @(negedge clk);
    @(negedge clk);
  endtask

  initial begin
    rst = 1'b1; load_start = 1'b0; byte_valid = 1'b0; byte_data = 8'h00; sum8 = 8'h00;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_byte_ready", {31'd0, byte_ready}, 32'd0);
    check("rst_imem_we",    {31'd0, imem_we},    32'd0);
    check("rst_imem_addr",  {22'd0, imem_addr},  32'd0);
    check("rst_imem_wdata", imem_wdata,          32'd0);
    check("rst_cpu_rst",    {31'd0, cpu_rst},    32'd1);
    check("rst_done",       {31'd0, done},       32'd0);
    check("rst_error",      {31'd0, error},      32'd0);
    @(posedge clk); #1;
    rst = 1'b0;

    // Normal two-word load at full rate
    exp_q.push_back({10'd0, 32'h1234_5678});
    exp_q.push_back({10'd1, 32'h9ABC_DEF0});
    start_load();
    send_byte(8'h00, 0); send_byte(8'h02, 0);
    send_data(8'h12, 0); send_data(8'h34, 0); send_data(8'h56, 0); send_data(8'h78, 0);
    send_data(8'h9A, 0); send_data(8'hBC, 0); send_data(8'hDE, 0); send_data(8'hF0, 0);
`ifdef IMEM_LOADER_CHECKSUM_EN
    end_frame();
    @(negedge clk);
`else
    @(negedge clk);
    check("last_we_pulse", {31'd0, imem_we}, 32'd1);
    check("done_lags_we",  {31'd0, done},    32'd0);
`endif
    @(negedge clk);
    check("norm_done",     {31'd0, done},       32'd1);
    check("norm_cpu_rst",  {31'd0, cpu_rst},    32'd0);
    check("norm_ready",    {31'd0, byte_ready}, 32'd0);
    check("norm_we_count", we_count,            32'd2);

    // Oversize frame
    snap = we_count;
    start_load();
    send_byte(8'h04, 0); send_byte(8'h01, 0);
    settle2();
    check("ovs_error",   {31'd0, error},   32'd1);
    check("ovs_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("ovs_done",    {31'd0, done},    32'd0);
    check("ovs_no_we",   we_count,         snap);

    // Zero length, then restart
    start_load();
    check("zl_error_clr", {31'd0, error}, 32'd0);
    send_byte(8'h00, 0); send_byte(8'h00, 0);
    end_frame();
    settle2();
    check("zl_done",    {31'd0, done},    32'd1);
    check("zl_cpu_rst", {31'd0, cpu_rst}, 32'd0);
    check("zl_no_we",   we_count,         snap);
    start_load();
    check("rs_done",    {31'd0, done},       32'd0);
    check("rs_cpu_rst", {31'd0, cpu_rst},    32'd1);
    check("rs_ready",   {31'd0, byte_ready}, 32'd1);

    // Stalled partial frame abandoned by reset
    send_byte(8'h00, 3); send_byte(8'h01, 3);
    send_data(8'hAA, 3); send_data(8'hBB, 3);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    repeat (6) @(posedge clk);
    @(negedge clk);
    check("mrst_ready",   {31'd0, byte_ready}, 32'd0);
    check("mrst_cpu_rst", {31'd0, cpu_rst},    32'd1);
    check("mrst_no_we",   we_count,            snap);

    // Fresh stalled load with an ignored load_start during DATA
    exp_q.push_back({10'd0, 32'hCAFE_BABE});
    start_load();
    send_byte(8'h00, 3); send_byte(8'h01, 3);
    send_data(8'hCA, 3); send_data(8'hFE, 3);
    load_start = 1'b1;
    @(posedge clk); #1;
    load_start = 1'b0;
    check("ign_start_ready", {31'd0, byte_ready}, 32'd1);
    send_data(8'hBA, 3); send_data(8'hBE, 3);
    end_frame();
    settle2();
    check("fresh_done",     {31'd0, done}, 32'd1);
    check("fresh_we_count", we_count,      snap + 1);

`ifdef IMEM_LOADER_CHECKSUM_EN
    exp_q.push_back({10'd0, 32'h0102_0304});
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF6, 0);
    settle2();
    check("csum_ok_done",  {31'd0, done},  32'd1);
    check("csum_ok_error", {31'd0, error}, 32'd0);
    exp_q.push_back({10'd0, 32'h0102_0304});
    start_load();
    send_byte(8'h00, 0); send_byte(8'h01, 0);
    send_byte(8'h01, 0); send_byte(8'h02, 0); send_byte(8'h03, 0); send_byte(8'h04, 0);
    send_byte(8'hF7, 0);
    settle2();
    check("csum_bad_error",   {31'd0, error},   32'd1);
    check("csum_bad_cpu_rst", {31'd0, cpu_rst}, 32'd1);
    check("csum_bad_done",    {31'd0, done},    32'd0);
`endif

    repeat (3) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
